uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage. It consumes the line produced by the team's uart_transmitter: idle-high, one start bit (0), UART_BITS_TRANSFERED data bits sent LSB first, and one stop bit (1). It oversamples rx by CLKS_PER_BIT, samples each bit at its mid-point, and delivers each word on a single-entry valid/ready output register. It flags framing errors and overruns.

Parameters:
UART_BITS_TRANSFERED, 8, data bits per frame (range 1..16).
CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and at least 4. HALF = CLKS_PER_BIT/2.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
rx  input  1  serial line, asynchronous to clk, idle high.
data_out  output  UART_BITS_TRANSFERED  last good received word.
valid_out  output  1  data_out holds an untransferred word.
ready_in  input  1  consumer accepts data_out this cycle.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: good word dropped because the buffer was full.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - Both synchronizer flops reset to 1.
  - State = IDLE, counters = 0, shift register = 0.
  - data_out = 0, valid_out = 0, frame_err = 0, overrun = 0, busy = 0.
  - Reset mid-frame discards the partial frame. No flag pulses.
- rx passes through a 2-flop synchronizer to give rx_s. rx_s lags rx by 2 clk edges. All decisions use rx_s.
- States: IDLE, START, DATA, STOP, BREAK.
- Let edge E be the edge at which IDLE sees rx_s == 0.
  - At E: go to START, clear cnt.
- START:
  - At edge E+HALF, sample rx_s.
  - If 0: go to DATA, bit_idx = 0, clear cnt.
  - If 1: treat as a glitch and return to IDLE. No flags.
- DATA:
  - Data bit i is sampled at edge E+HALF+(i+1)*CLKS_PER_BIT.
  - Each sample is shifted in LSB first, so bit 0 lands in data_out[0].
  - After bit UART_BITS_TRANSFERED-1 is sampled, go to STOP.
- STOP:
  - Sample at edge S = E+HALF+(UART_BITS_TRANSFERED+1)*CLKS_PER_BIT.
  - If rx_s == 1 (good frame): go to IDLE at S. The next start edge can be detected from S+1, so back-to-back frames are supported.
  - If rx_s == 0: pulse frame_err for the cycle after S. Discard the word. Go to BREAK.
- BREAK:
  - Stay until rx_s == 1, then go to IDLE.
  - A held-low line never produces repeated frames or repeated frame_err pulses.
- Output buffer, evaluated at S on a good frame:
  - If valid_out == 0, or valid_out && ready_in in the same cycle: load data_out, valid_out = 1 after S.
  - If valid_out && !ready_in: keep the old data_out and valid_out, drop the new word, pulse overrun for 1 cycle.
- Handshake:
  - A transfer occurs on any edge where valid_out && ready_in.
  - valid_out clears after that edge unless a new word loads on the same edge.
  - data_out is stable while valid_out is high and ready_in is low.
  - ready_in is ignored while valid_out == 0.
- frame_err and overrun never assert in the same cycle. They are registered outputs.
- busy is registered from the state. It rises the cycle after E and falls the cycle after the transition back to IDLE.
- Counters: cnt is $clog2(CLKS_PER_BIT) bits and wraps only under explicit clear. bit_idx is $clog2(UART_BITS_TRANSFERED+1) bits.
- Latency: the rx falling edge to valid_out high is 2 + HALF + (UART_BITS_TRANSFERED+1)*CLKS_PER_BIT + 1 edges (nominal, with an ideal line).

Test Plan:
All scenarios use the defaults (W = 8, CLKS_PER_BIT = 16), ready_in = 1 unless stated, and drive rx at 16 clk per bit.
1. Frame 0xA5 → data_out = 0xA5 and valid_out high for exactly 1 cycle, at edge E+152+1. frame_err = 0, overrun = 0.
2. Frames 0x00 then 0xFF back-to-back with no idle gap → both words received in order. busy returns to 0 only after the second frame.
3. rx low for 4 cycles then high → no valid_out, no flags. busy high for HALF cycles then 0.
4. Frame 0x3C with stop bit 0 → frame_err pulse for 1 cycle, valid_out stays 0. Hold rx low for 40 more cycles → no further pulses and busy stays 1. Release rx high → IDLE, then the next frame 0x5A is received.
5. ready_in = 0; frames 0x11 then 0x22 → data_out = 0x11 held. overrun pulses at the second stop sample. Then ready_in = 1 → valid_out clears after 1 cycle and 0x22 is never presented.
6. Assert rst during DATA bit 3 of frame 0xC3 → all outputs 0 and busy 0 immediately. Release rst, then send 0x96 → data_out = 0x96 with no flags.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchronised rx, mid-bit sampling, LSB-first framing into a single-entry output register.
// Latency: rx falling edge to valid_out is 2 + HALF + (bits+1)*CLKS_PER_BIT + 1 clk edges.
// Backpressure: valid/ready output register; a good word arriving while it is still full is dropped and flagged by overrun.
module uart_receiver #(
    parameter int UART_BITS_TRANSFERED = 8,
    parameter int CLKS_PER_BIT         = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    output logic [UART_BITS_TRANSFERED-1:0] data_out,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic                            frame_err,
    output logic                            overrun,
    output logic                            busy
);
    localparam int W    = UART_BITS_TRANSFERED;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(UART_BITS_TRANSFERED + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic          sync1;
    logic          rx_s;
    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic [W-1:0]  shreg;
    logic          cnt_clr;
    logic          counting;
    logic          sample_bit;
    logic          stop_good;
    logic          stop_bad;

    // Synchroniser resets high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    assign counting = (state == START) || (state == DATA) || (state == STOP);

    always_comb begin
        nxt        = state;
        cnt_clr    = 1'b0;
        sample_bit = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    nxt     = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                // Start bit re-checked at mid-point; a high here was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    nxt     = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_clr    = 1'b1;
                    sample_bit = 1'b1;
                    if (bit_idx == BIT_LAST) nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        nxt       = IDLE;
                        stop_good = 1'b1;
                    end else begin
                        nxt      = BRK;
                        stop_bad = 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= (nxt != IDLE);

            if (cnt_clr)       cnt <= '0;
            else if (counting) cnt <= cnt + 1'b1;

            if (state != DATA)   bit_idx <= '0;
            else if (sample_bit) bit_idx <= bit_idx + 1'b1;

            // New bit enters at the MSB so the first bit ends up in bit 0.
            if (sample_bit) shreg <= W'({rx_s, shreg} >> 1);

            frame_err <= stop_bad;
            overrun   <= stop_good && valid_out && !ready_in;

            if (stop_good && (!valid_out || ready_in)) begin
                data_out  <= shreg;
                valid_out <= 1'b1;
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected words/flags, a monitor pops on each handshake or flag pulse.
module tb_uart_receiver;
    localparam int W    = 8;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + (W + 1) * CPB + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx = 1'b1;
    logic         ready_in = 1'b1;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_fall = 0;
    bit lat_arm = 1'b0;

    logic [W-1:0] exp_data[$];
    int exp_ferr = 0;
    int exp_ovr = 0;
    bit model_full = 1'b0;

    uart_receiver #(.UART_BITS_TRANSFERED(W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .valid_out(valid_out),
        .ready_in(ready_in), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: a good frame is kept if the single slot is free, otherwise dropped with overrun.
    task automatic send_frame(input logic [W-1:0] d, input bit stop_ok, input int hold_low);
        if (ready_in) model_full = 1'b0;
        if (!stop_ok) exp_ferr++;
        else if (!model_full) begin
            exp_data.push_back(d);
            model_full = !ready_in;
        end else exp_ovr++;
        rx = 1'b0;
        t_fall = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < W; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        if (!stop_ok) begin
            repeat (hold_low) @(negedge clk);
            chk("break_busy", busy, 1);
            rx = 1'b1;
            repeat (4) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        logic         pv;
        logic         pr;
        logic [W-1:0] pd;
        logic [W-1:0] e;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (valid_out && lat_arm) begin
                    chk("latency", cyc - t_fall, LAT);
                    lat_arm = 1'b0;
                end
                if (pv && !pr && valid_out) chk("hold_stable", data_out, pd);
                if (valid_out && ready_in) begin
                    if (exp_data.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL word: got %0h want none", data_out);
                    end else begin
                        e = exp_data.pop_front();
                        chk("word", data_out, e);
                    end
                end
                if (frame_err || overrun) chk("flags_exclusive", frame_err & overrun, 0);
                if (frame_err) begin
                    total++;
                    if (exp_ferr > 0) exp_ferr--;
                    else begin
                        bad++;
                        $display("FAIL frame_err: got pulse want none");
                    end
                end
                if (overrun) begin
                    total++;
                    if (exp_ovr > 0) exp_ovr--;
                    else begin
                        bad++;
                        $display("FAIL overrun: got pulse want none");
                    end
                end
                pv = valid_out;
                pr = ready_in;
                pd = data_out;
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        lat_arm = 1'b1;
        send_frame(8'hA5, 1'b1, 0);
        repeat (20) @(negedge clk);
        chk("lat_seen", lat_arm, 0);

        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        repeat (2) @(negedge clk);
        chk("b2b_busy_end", busy, 0);
        repeat (10) @(negedge clk);

        rx = 1'b0;
        nb = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) rx = 1'b1;
            @(negedge clk);
            if (busy) nb++;
        end
        chk("glitch_busy", nb, HALF);
        repeat (10) @(negedge clk);

        send_frame(8'h3C, 1'b0, 40);
        send_frame(8'h5A, 1'b1, 0);
        repeat (20) @(negedge clk);

        ready_in = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        repeat (10) @(negedge clk);
        chk("ovr_valid", valid_out, 1);
        chk("ovr_data", data_out, 8'h11);
        ready_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("ovr_drain", valid_out, 0);
        repeat (10) @(negedge clk);

        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0 || i == 1) ? 1'b1 : 1'b0;
            repeat ((i == 3) ? HALF : CPB) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_flags", {frame_err, overrun}, 0);
        rx = 1'b1;
        model_full = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h96, 1'b1, 0);
        repeat (20) @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            ready_in = 1'($urandom_range(0, 1));
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0, $urandom_range(0, 20));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        ready_in = 1'b1;
        repeat (40) @(negedge clk);

        chk("drain_words", exp_data.size(), 0);
        chk("drain_ferr", exp_ferr, 0);
        chk("drain_ovr", exp_ovr, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
